// File: rtl/spi_timer_regs_if.sv
// SPI pins and timer-side words of the SPI timer register bank.
// The _i/_o suffixes are seen from the register bank (slave side).
interface spi_timer_regs_if #(
   parameter int CTSW_DWIDTH = 24
) ();
   logic                   spi_sclk_i;
   logic                   spi_cs_n_i;
   logic                   spi_mosi_i;
   logic                   spi_miso_o;
   logic                   spi_miso_oe_o;
   logic [CTSW_DWIDTH-1:0] timer_data_l_o;
   logic [CTSW_DWIDTH-1:0] timer_data_h_o;
   logic                   timer_load_o;
   logic                   timer_done_i;

   modport slave (
      input  spi_sclk_i, spi_cs_n_i, spi_mosi_i, timer_done_i,
      output spi_miso_o, spi_miso_oe_o, timer_data_l_o, timer_data_h_o, timer_load_o
   );

   modport master (
      output spi_sclk_i, spi_cs_n_i, spi_mosi_i, timer_done_i,
      input  spi_miso_o, spi_miso_oe_o, timer_data_l_o, timer_data_h_o, timer_load_o
   );
endinterface

// File: rtl/spi_timer_regs.sv
// SPI slave register bank feeding the timer: decodes 8-bit command plus
// CTSW_DWIDTH-bit data frames, drives the timer phase words and a sticky
// done status. SCLK/CS_N/MOSI are oversampled in the clk domain.
module spi_timer_regs #(
   parameter int CTSW_DWIDTH = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   spi_timer_regs_if.slave bus
);

   localparam logic [6:0] ADDR_L  = 7'h01;
   localparam logic [6:0] ADDR_H  = 7'h02;
   localparam logic [6:0] ADDR_ST = 7'h04;
   localparam int CNT_W   = $clog2(CTSW_DWIDTH + 8);
   // Synchronizer reset values are not real pin samples; wait this many
   // clocks after reset so the chain and the edge flop hold real data.
   localparam int FLUSH_N = SYNC_STAGES + 1;
   localparam int FL_W    = $clog2(FLUSH_N + 1);

   typedef enum logic [2:0] {
      ST_WAIT_IDLE = 3'd0,
      ST_IDLE      = 3'd1,
      ST_CMD       = 3'd2,
      ST_DATA      = 3'd3,
      ST_END       = 3'd4
   } state_t;

   // Returns the readable value of an address; unmapped addresses read 0.
   function automatic logic [CTSW_DWIDTH-1:0] read_mux(
      input logic [6:0]             addr,
      input logic [CTSW_DWIDTH-1:0] l_val,
      input logic [CTSW_DWIDTH-1:0] h_val,
      input logic                   sticky
   );
      logic [CTSW_DWIDTH-1:0] v;
      case (addr)
         ADDR_L:  v = l_val;
         ADDR_H:  v = h_val;
         ADDR_ST: v = {{(CTSW_DWIDTH-1){1'b0}}, sticky};
         default: v = {CTSW_DWIDTH{1'b0}};
      endcase
      return v;
   endfunction

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cs_s, sclk_s, mosi_s;
   logic                   cs_rise_s, cs_fall_s, sclk_rise_s, sclk_fall_s;

   state_t                 state_q, state_d;
   logic [FL_W-1:0]        flush_q, flush_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             cmd_q, cmd_d, cmd_next_s;
   logic [CTSW_DWIDTH-1:0] shift_q, shift_d;
   logic [CTSW_DWIDTH-1:0] shadow_q, shadow_d;
   logic                   miso_q, miso_d;
   logic                   oe_q, oe_d;
   logic [CTSW_DWIDTH-1:0] data_l_q, data_l_d;
   logic [CTSW_DWIDTH-1:0] data_h_q, data_h_d;
   logic                   load_q, load_d;
   logic                   done_prev_q;
   logic                   sticky_q, sticky_d;
   logic                   sticky_clr_s, done_rise_s;

   // Synchronizer chains plus one extra flop per edge-detected input.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_sync_q <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n_i};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign cs_rise_s   = cs_s & ~cs_prev_q;
   assign cs_fall_s   = ~cs_s & cs_prev_q;
   assign sclk_rise_s = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s = ~sclk_s & sclk_prev_q;

   // Frame FSM: next state, shifting, MISO serialisation and commit decode.
   always_comb begin
      state_d      = state_q;
      flush_d      = flush_q;
      cnt_d        = cnt_q;
      cmd_d        = cmd_q;
      shift_d      = shift_q;
      shadow_d     = shadow_q;
      miso_d       = miso_q;
      oe_d         = oe_q;
      data_l_d     = data_l_q;
      data_h_d     = data_h_q;
      load_d       = 1'b0;
      sticky_clr_s = 1'b0;
      cmd_next_s   = {cmd_q[6:0], mosi_s};

      case (state_q)
         ST_WAIT_IDLE: begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
            if (flush_q != FL_W'(FLUSH_N)) begin
               flush_d = flush_q + FL_W'(1);
            end else if (cs_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end

         ST_IDLE: begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
            if (cs_fall_s) begin
               cnt_d   = {CNT_W{1'b0}};
               oe_d    = 1'b1;
               state_d = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CMD: begin
            miso_d = 1'b0;
            if (cs_rise_s) begin
               oe_d    = 1'b0;
               state_d = ST_IDLE;
            end else if (sclk_rise_s) begin
               cmd_d = cmd_next_s;
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d    = {CNT_W{1'b0}};
                  shadow_d = cmd_next_s[7] ? read_mux(cmd_next_s[6:0], data_l_q, data_h_q, sticky_q)
                                           : {CTSW_DWIDTH{1'b0}};
                  state_d  = ST_DATA;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_CMD;
            end
         end

         ST_DATA: begin
            if (cs_rise_s) begin
               miso_d  = 1'b0;
               oe_d    = 1'b0;
               state_d = ST_IDLE;
            end else if (sclk_rise_s) begin
               shift_d = {shift_q[CTSW_DWIDTH-2:0], mosi_s};
               if (cnt_q == CNT_W'(CTSW_DWIDTH - 1)) begin
                  state_d = ST_END;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall_s) begin
               miso_d   = shadow_q[CTSW_DWIDTH-1];
               shadow_d = {shadow_q[CTSW_DWIDTH-2:0], 1'b0};
            end else begin
               state_d = ST_DATA;
            end
         end

         ST_END: begin
            if (cs_rise_s) begin
               miso_d  = 1'b0;
               oe_d    = 1'b0;
               state_d = ST_IDLE;
               if (!cmd_q[7]) begin
                  case (cmd_q[6:0])
                     ADDR_L: begin
                        data_l_d = shift_q;
                        load_d   = 1'b1;
                     end
                     ADDR_H: begin
                        data_h_d = shift_q;
                        load_d   = 1'b1;
                     end
                     default: load_d = 1'b0;
                  endcase
               end else begin
                  sticky_clr_s = (cmd_q[6:0] == ADDR_ST);
               end
            end else begin
               state_d = ST_END;
            end
         end

         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase
   end

   assign done_rise_s = bus.timer_done_i & ~done_prev_q;

   // Sticky done: a new rising edge wins over a same-cycle status-read clear.
   always_comb begin
      if (done_rise_s) begin
         sticky_d = 1'b1;
      end else if (sticky_clr_s) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT_IDLE;
         flush_q     <= {FL_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         cmd_q       <= 8'h00;
         shift_q     <= {CTSW_DWIDTH{1'b0}};
         shadow_q    <= {CTSW_DWIDTH{1'b0}};
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         data_l_q    <= {CTSW_DWIDTH{1'b0}};
         data_h_q    <= {CTSW_DWIDTH{1'b0}};
         load_q      <= 1'b0;
         done_prev_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         shift_q     <= shift_d;
         shadow_q    <= shadow_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         data_l_q    <= data_l_d;
         data_h_q    <= data_h_d;
         load_q      <= load_d;
         done_prev_q <= bus.timer_done_i;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.spi_miso_o     = miso_q;
   assign bus.spi_miso_oe_o  = oe_q;
   assign bus.timer_data_l_o = data_l_q;
   assign bus.timer_data_h_o = data_h_q;
   assign bus.timer_load_o   = load_q;

endmodule

// File: doc/spi_timer_regs.md
Name: spi_timer_regs

Overview:
SPI slave register bank that sits directly upstream of the timer block. It decodes 32-bit SPI frames from the host and drives the timer's low/high phase words (timer_data_l/timer_data_h). It also latches the timer's done indication into a readable status register. All logic runs in the clk domain; SCLK, CS_N and MOSI are oversampled through synchronizers.

Parameters:
CTSW_DWIDTH, 24, width of each timer data register and of the SPI data field
SYNC_STAGES, 2, synchronizer depth for spi_sclk_i, spi_cs_n_i, spi_mosi_i (min 2)

Ports:
clk  input  1  system clock (100 MHz nominal)
rst  input  1  synchronous reset, active-high
spi_sclk_i  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), f_sclk <= f_clk/8
spi_cs_n_i  input  1  SPI chip select, active-low
spi_mosi_i  input  1  SPI data in, MSB first
spi_miso_o  output  1  SPI data out, MSB first
spi_miso_oe_o  output  1  MISO output enable, high while a frame is active
timer_data_l_o  output  CTSW_DWIDTH  to timer_data_l_i
timer_data_h_o  output  CTSW_DWIDTH  to timer_data_h_i
timer_load_o  output  1  one-clk pulse when either data register is updated
timer_done_i  input  1  from timer_done_o; same clock domain

Behaviour:
- Reset values: timer_data_l_o=0, timer_data_h_o=0, timer_load_o=0, spi_miso_o=0, spi_miso_oe_o=0, status=0. FSM enters WAIT_IDLE.
- Synchronizer flops reset to: CS_N=1, SCLK=0, MOSI=0. Edge detects use the last two synced samples.
- Frame format: 8-bit command, then CTSW_DWIDTH data bits, for 32 bits total.
  - Command bit7: 0 = write, 1 = read. Bits[6:0] are the address.
- Address map:
  - 0x01: L register, R/W.
  - 0x02: H register, R/W.
  - 0x04: STATUS, RO. Bit0 = done_sticky, other bits 0.
  - Other addresses: writes ignored, reads return 0.
- FSM states:
  - WAIT_IDLE: stay until synced CS_N=1 for 1 clk, then go to IDLE. This guarantees that a reset mid-frame never decodes a partial frame.
  - IDLE: on synced CS_N falling edge, clear the bit counter and go to CMD. Set miso_oe=1.
  - CMD: shift MOSI in on each synced SCLK rising edge. After the 8th bit, latch the command and go to DATA.
  - DATA: keep shifting MOSI in on rising edges. After CTSW_DWIDTH bits, go to END.
  - END: extra SCLK edges are ignored. On synced CS_N rising edge, commit the frame and return to IDLE.
  - CS_N rising edge in CMD or DATA (short frame): abort, no register change, no clear of status, return to IDLE.
- Commit (write):
  - The addressed register takes the received data on the clk after CS_N rising is detected.
  - timer_load_o pulses high for exactly that clk.
  - Latency from raw CS_N rise to output change is <= SYNC_STAGES+2 clk.
- MISO:
  - Driven 0 during CMD.
  - On read commands, a read shadow is loaded with the addressed value when the command byte completes. The MSB appears on the next synced SCLK falling edge, then one bit is shifted per falling edge.
  - Write commands drive MISO 0 throughout.
  - When CS_N is high: spi_miso_o=0, spi_miso_oe_o=0.
- done_sticky:
  - Set on a timer_done_i rising edge (0->1 between consecutive clks).
  - Cleared at commit of a complete STATUS read.
  - If set and clear fall on the same clk, set wins and the bit stays 1.
- Reads have no side effects except clearing STATUS.
- rst asserted mid-frame: all outputs return to reset values and the FSM goes to WAIT_IDLE. The remainder of the frame is ignored.

Test Plan:
- Write L: cs low, shift 0x01 then 0x01012C, cs high -> timer_data_l_o=0x01012C within 4 clk of cs rise; timer_load_o high 1 clk; timer_data_h_o stays 0.
- Write H then readback: write 0x02 with 0x010000, then read frame 0x82 -> MISO returns 0x010000 MSB-first on data bits; timer_data_h_o=0x010000; no load pulse on the read.
- Done status: pulse timer_done_i for 1 clk, then read 0x84 -> data 0x000001. A second read of 0x84 returns 0x000000. With timer_done_i rising in the same clk as the first read's commit, the second read returns 0x000001.
- Aborted frame: cs low, shift 0x01 plus 10 data bits of 0x3FF, cs high -> timer_data_l_o unchanged, no load pulse. The next full frame writing 0x00012C is accepted correctly.
- Reset mid-frame: after 12 bits of a write to 0x01, assert rst 1 clk with cs still low, then finish the 20 remaining bits -> no update and outputs stay 0. After cs rises, a new full write of 0x000005 lands.
- Unknown address and overlong frame: write 0x7F with 0xABCDEF -> no register change. Write 0x01 with 0x00012C followed by 8 extra SCLK cycles -> L=0x00012C.
